// File: rtl/podule_bus.sv
// ---------------------------------------------------------------------------
// podule_bus
//   Expansion (podule) bus controller. Sits between the IOC-decoded podule
//   window and up to four podule cards (slot 0 = IDE). Routes each CPU cycle
//   to a slot by address, runs a registered per-slot ack handshake, muxes the
//   read data back and merges the per-slot interrupt requests into pirq/pfiq.
//
//   Optional feature macro: PODULE_TIMEOUT_EN
//     defined   : ACCESS watchdog. A slot that does not ack within TIMEOUT
//                 ACCESS cycles is cut off, bus_dat_o = FFFF, timeout_err set.
//     undefined : ACCESS waits for the slot indefinitely, timeout_err = 0.
//
// Parameters
//   NUM_SLOTS  populated slots, 1..4 (slot index = bus_adr[13:12])
//   TIMEOUT    watchdog limit in ACCESS cycles, 2..65535
//
// Ports
//   clkcpu, rst_n      clock, asynchronous active-low reset
//   bus_sel/we/adr     CPU request (adr = cpu_address[15:2])
//   bus_dat_i/o        write data in, registered read data out
//   bus_ack            one-cycle completion strobe
//   slot_sel           one-hot slot strobe, held for the whole access
//   slot_we/adr/dat_o  latched write enable, offset and write data
//   slot_dat_i         per-slot read data, slot n at [16n+15:16n]
//   slot_ack           per-slot completion, honoured only for the selected slot
//   slot_present       1 = card fitted
//   slot_irq/firq      level interrupt requests
//   pirq/pfiq          registered OR of requests from fitted cards
//   timeout_err        sticky watchdog flag (cleared only by reset)
//   dbg_state          current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake: the CPU side holds bus_sel high until it has seen bus_ack; a
// cycle starts only when bus_sel is seen in IDLE, and after completion the
// controller waits for bus_sel to drop before accepting another. On the slot
// side slot_sel (with we/adr/dat) is held stable until the selected slot
// returns slot_ack, which completes the transfer in that same cycle.
// ---------------------------------------------------------------------------
module podule_bus #(
   parameter int NUM_SLOTS = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clkcpu,
   input  logic                    rst_n,
   input  logic                    bus_sel,
   input  logic                    bus_we,
   input  logic [13:0]             bus_adr,
   input  logic [15:0]             bus_dat_i,
   output logic [15:0]             bus_dat_o,
   output logic                    bus_ack,
   output logic [NUM_SLOTS-1:0]    slot_sel,
   output logic                    slot_we,
   output logic [11:0]             slot_adr,
   output logic [15:0]             slot_dat_o,
   input  logic [16*NUM_SLOTS-1:0] slot_dat_i,
   input  logic [NUM_SLOTS-1:0]    slot_ack,
   input  logic [NUM_SLOTS-1:0]    slot_present,
   input  logic [NUM_SLOTS-1:0]    slot_irq,
   input  logic [NUM_SLOTS-1:0]    slot_firq,
   output logic                    pirq,
   output logic                    pfiq,
   output logic                    timeout_err,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   if (NUM_SLOTS < 1 || NUM_SLOTS > 4 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("podule_bus: NUM_SLOTS must be 1..4 and TIMEOUT 2..65535");
   end

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_slot;
   logic        r_sel_on;
   logic        r_we;
   logic [11:0] r_adr;
   logic [15:0] r_wdat;
   logic [15:0] r_bus_dat;
   logic        r_bus_ack;
   logic        r_ack_sent;
   logic        r_pirq;
   logic        r_pfiq;

   logic [1:0]  w_req_slot;
   logic        w_req_present;
   logic        w_start;
   logic        w_finish_ack;
   logic        w_finish_to;
   logic        w_cnt_hit;

   // All per-slot inputs are widened to four lanes so the 2-bit slot index
   // can address them directly; unfitted lanes read as absent / no ack.
   logic [3:0]  w_present4;
   logic [3:0]  w_ack4;
   logic [15:0] w_dat4 [4];

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NUM_SLOTS) begin : g_fit
         assign w_present4[gi] = slot_present[gi];
         assign w_ack4[gi]     = slot_ack[gi];
         assign w_dat4[gi]     = slot_dat_i[16*gi +: 16];
         assign slot_sel[gi]   = r_sel_on && (r_slot == 2'(gi));
      end else begin : g_empty
         assign w_present4[gi] = 1'b0;
         assign w_ack4[gi]     = 1'b0;
         assign w_dat4[gi]     = 16'hFFFF;
      end
   end

   assign w_req_slot    = bus_adr[13:12];
   assign w_req_present = w_present4[w_req_slot];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_start      = 1'b0;
      w_finish_ack = 1'b0;
      w_finish_to  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus_sel) begin
               w_start = 1'b1;
               w_next  = w_req_present ? ST_ACCESS : ST_DONE;
            end
         end
         ST_ACCESS: begin
            // A real ack in the watchdog's last cycle still wins.
            if (w_ack4[r_slot]) begin
               w_finish_ack = 1'b1;
               w_next       = ST_DONE;
            end else if (w_cnt_hit) begin
               w_finish_to = 1'b1;
               w_next      = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!bus_sel) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         r_slot      <= 2'd0;
         r_sel_on    <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= 12'd0;
         r_wdat      <= 16'd0;
         r_bus_dat   <= 16'hFFFF;
         r_bus_ack   <= 1'b0;
         r_ack_sent  <= 1'b0;
         r_pirq      <= 1'b0;
         r_pfiq      <= 1'b0;
      end else begin
         // bus_ack fires on the first DONE cycle only; r_ack_sent remembers
         // that it has gone out until the FSM leaves DONE.
         r_bus_ack  <= (r_state == ST_DONE) && !r_ack_sent;
         r_ack_sent <= (r_state == ST_DONE);

         if (w_start) begin
            r_slot   <= w_req_slot;
            r_we     <= bus_we;
            r_adr    <= bus_adr[11:0];
            r_wdat   <= bus_dat_i;
            r_sel_on <= w_req_present;
            if (!w_req_present) begin
               r_bus_dat <= 16'hFFFF;
            end
         end

         if (w_finish_ack) begin
            r_sel_on <= 1'b0;
            if (!r_we) begin
               r_bus_dat <= w_dat4[r_slot];
            end
         end

         if (w_finish_to) begin
            r_sel_on  <= 1'b0;
            r_bus_dat <= 16'hFFFF;
         end

         r_pirq <= |(slot_irq & slot_present);
         r_pfiq <= |(slot_firq & slot_present);
      end
   end

`ifdef PODULE_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_timeout_err;

   assign w_cnt_hit = (r_cnt == 16'(TIMEOUT - 1));

   // r_cnt holds the number of completed ACCESS cycles of the current access.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= 16'd0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_start) begin
            r_cnt <= 16'd0;
         end else if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_finish_to) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_cnt_hit   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign bus_dat_o  = r_bus_dat;
   assign bus_ack    = r_bus_ack;
   assign slot_we    = r_we;
   assign slot_adr   = r_adr;
   assign slot_dat_o = r_wdat;
   assign pirq       = r_pirq;
   assign pfiq       = r_pfiq;
   assign dbg_state  = r_state;

endmodule
